// File: rtl/pipelined_core_p.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) with a unified word memory.
// Interlocks on register hazards instead of forwarding; branches resolve in ID.
module pipelined_core_p #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MEM_AW   = 7,
  parameter int unsigned START_PC = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              STEP_MODE,
  input  logic              STEP,
  input  logic              PROG_WE,
  input  logic [MEM_AW-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_DATA,
  input  logic              RUN,
  input  logic [2:0]        DBG_SEL,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic [MEM_AW-1:0] PC,
  output logic [2:0]        CC,
  output logic              HALTED,
  output logic [15:0]       RETIRED
);

  localparam logic [3:0] OP_BR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;
  localparam int unsigned MEM_D  = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0] PC_RST = MEM_AW'(START_PC);

  logic [DATA_W-1:0] r_mem [MEM_D];
  logic [DATA_W-1:0] r_rf  [8];

  logic [MEM_AW-1:0] r_pc;
  logic [2:0]        r_cc;
  logic              r_halted;
  logic [15:0]       r_retired;

  logic              r_id_v;
  logic [15:0]       r_id_ir;
  logic [MEM_AW-1:0] r_id_pc;

  logic              r_ex_v, r_ex_we;
  logic [3:0]        r_ex_op;
  logic [2:0]        r_ex_dr;
  logic [DATA_W-1:0] r_ex_a, r_ex_b, r_ex_sd;

  logic              r_mem_v, r_mem_we;
  logic [3:0]        r_mem_op;
  logic [2:0]        r_mem_dr;
  logic [DATA_W-1:0] r_mem_res, r_mem_sd;

  logic              r_wb_v, r_wb_we;
  logic [2:0]        r_wb_dr;
  logic [DATA_W-1:0] r_wb_res;

  function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1])   return 3'b100;
    else if (v == '0)  return 3'b010;
    else               return 3'b001;
  endfunction

  // ID decode
  logic [3:0]  w_op;
  logic [2:0]  w_dr, w_sr1, w_sr2;
  logic        w_id_br, w_id_halt, w_id_alu, w_id_not, w_id_ld, w_id_st, w_id_we;
  logic        w_use1, w_use2, w_use_dr;
  assign w_op      = r_id_ir[15:12];
  assign w_dr      = r_id_ir[11:9];
  assign w_sr1     = r_id_ir[8:6];
  assign w_sr2     = r_id_ir[2:0];
  assign w_id_br   = r_id_v && (w_op == OP_BR) && (r_id_ir != 16'h0000);
  assign w_id_halt = r_id_v && (w_op == OP_HALT);
  assign w_id_alu  = r_id_v && ((w_op == OP_ADD) || (w_op == OP_AND));
  assign w_id_not  = r_id_v && (w_op == OP_NOT);
  assign w_id_ld   = r_id_v && (w_op == OP_LD);
  assign w_id_st   = r_id_v && (w_op == OP_ST);
  assign w_id_we   = w_id_alu || w_id_not || w_id_ld;
  assign w_use1    = w_id_alu || w_id_not || w_id_ld || w_id_st;
  assign w_use2    = w_id_alu && !r_id_ir[5];
  assign w_use_dr  = w_id_st;

  logic w_ex_w, w_mem_w, w_wb_w;
  assign w_ex_w  = r_ex_v && r_ex_we;
  assign w_mem_w = r_mem_v && r_mem_we;
  assign w_wb_w  = r_wb_v && r_wb_we;

  logic w_hz1, w_hz2, w_hzd, w_hazard;
  assign w_hz1 = w_use1 && ((w_ex_w && r_ex_dr == w_sr1) || (w_mem_w && r_mem_dr == w_sr1));
  assign w_hz2 = w_use2 && ((w_ex_w && r_ex_dr == w_sr2) || (w_mem_w && r_mem_dr == w_sr2));
  assign w_hzd = w_use_dr && ((w_ex_w && r_ex_dr == w_dr) || (w_mem_w && r_mem_dr == w_dr));
  assign w_hazard = w_hz1 || w_hz2 || w_hzd;

  // Register reads see the value being written back this cycle
  logic [DATA_W-1:0] w_a, w_r2, w_rd, w_b;
  assign w_a  = (w_wb_w && r_wb_dr == w_sr1) ? r_wb_res : r_rf[w_sr1];
  assign w_r2 = (w_wb_w && r_wb_dr == w_sr2) ? r_wb_res : r_rf[w_sr2];
  assign w_rd = (w_wb_w && r_wb_dr == w_dr)  ? r_wb_res : r_rf[w_dr];

  always_comb begin
    w_b = w_r2;
    if (w_id_ld || w_id_st)      w_b = DATA_W'($signed(r_id_ir[5:0]));
    else if (r_id_ir[5])         w_b = DATA_W'($signed(r_id_ir[4:0]));
  end

  // Branch waits until no CC-setting instruction remains in flight
  logic              w_br_wait, w_taken, w_stall, w_halt_now, w_adv, w_run;
  logic [MEM_AW-1:0] w_br_tgt;
  assign w_br_wait  = w_id_br && (w_ex_w || w_mem_w || w_wb_w);
  assign w_taken    = w_id_br && !w_br_wait && ((r_id_ir[11:9] & r_cc) != 3'b000);
  assign w_br_tgt   = r_id_pc + MEM_AW'(1) + MEM_AW'($signed(r_id_ir[8:0]));
  assign w_stall    = w_hazard || w_br_wait || w_id_halt;
  assign w_halt_now = w_id_halt && !r_ex_v && !r_mem_v;
  assign w_adv      = !STEP_MODE || STEP;
  assign w_run      = w_adv && !r_halted;

  logic [DATA_W-1:0] w_ex_res;
  always_comb begin
    w_ex_res = '0;
    case (r_ex_op)
      OP_ADD, OP_LD, OP_ST: w_ex_res = r_ex_a + r_ex_b;
      OP_AND:               w_ex_res = r_ex_a & r_ex_b;
      OP_NOT:               w_ex_res = ~r_ex_a;
      default:              w_ex_res = '0;
    endcase
  end

  logic [MEM_AW-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_val;
  logic              w_st_we;
  assign w_mem_addr = r_mem_res[MEM_AW-1:0];
  assign w_mem_val  = (r_mem_op == OP_LD) ? r_mem[w_mem_addr] : r_mem_res;
  assign w_st_we    = w_run && r_mem_v && (r_mem_op == OP_ST);

  // Memory has no reset so a loaded program survives RESET_N
  always_ff @(posedge CLOCK_50) begin
    if (r_halted && PROG_WE) r_mem[PROG_ADDR] <= PROG_DATA;
    else if (w_st_we)        r_mem[w_mem_addr] <= r_mem_sd;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc      <= PC_RST;
      r_cc      <= 3'b010;
      r_halted  <= 1'b1;
      r_retired <= '0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      r_id_v    <= 1'b0;
      r_id_ir   <= '0;
      r_id_pc   <= '0;
      r_ex_v    <= 1'b0;
      r_ex_we   <= 1'b0;
      r_ex_op   <= '0;
      r_ex_dr   <= '0;
      r_ex_a    <= '0;
      r_ex_b    <= '0;
      r_ex_sd   <= '0;
      r_mem_v   <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_op  <= '0;
      r_mem_dr  <= '0;
      r_mem_res <= '0;
      r_mem_sd  <= '0;
      r_wb_v    <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_dr   <= '0;
      r_wb_res  <= '0;
    end else if (w_adv) begin
      if (r_halted) begin
        if (RUN) begin
          r_halted <= 1'b0;
          r_pc     <= PC_RST;
        end
      end else begin
        if (w_halt_now) begin
          r_halted <= 1'b1;
          r_id_v   <= 1'b0;
        end else if (!w_stall) begin
          r_pc    <= w_taken ? w_br_tgt : r_pc + MEM_AW'(1);
          r_id_v  <= !w_taken;
          r_id_ir <= r_mem[r_pc][15:0];
          r_id_pc <= r_pc;
        end
        r_ex_v    <= r_id_v && !w_stall;
        r_ex_we   <= w_id_we;
        r_ex_op   <= w_op;
        r_ex_dr   <= w_dr;
        r_ex_a    <= w_a;
        r_ex_b    <= w_b;
        r_ex_sd   <= w_rd;
        r_mem_v   <= r_ex_v;
        r_mem_we  <= r_ex_we;
        r_mem_op  <= r_ex_op;
        r_mem_dr  <= r_ex_dr;
        r_mem_res <= w_ex_res;
        r_mem_sd  <= r_ex_sd;
        r_wb_v    <= r_mem_v;
        r_wb_we   <= r_mem_we;
        r_wb_dr   <= r_mem_dr;
        r_wb_res  <= w_mem_val;
        if (w_wb_w) begin
          r_rf[r_wb_dr] <= r_wb_res;
          r_cc          <= cc_of(r_wb_res);
        end
        if (r_wb_v) r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign DBG_DATA = r_rf[DBG_SEL];
  assign PC       = r_pc;
  assign CC       = r_cc;
  assign HALTED   = r_halted;
  assign RETIRED  = r_retired;

endmodule
